// File: rtl/ppu_pkg.sv
// Shared types, constants and fetch-address helpers for the PPU background datapath.
package ppu_pkg;

    typedef logic [14:0] loopy_t;

    typedef enum logic [1:0] {
        FK_NT,
        FK_AT,
        FK_PT_LO,
        FK_PT_HI
    } fetch_kind_e;

    localparam logic [13:0] NT_BASE            = 14'h2000;
    localparam logic [13:0] AT_BASE            = 14'h23C0;
    localparam logic [8:0]  FETCH_LAST_VISIBLE = 9'd256;
    localparam logic [8:0]  PREFETCH_FIRST     = 9'd321;
    localparam logic [8:0]  PREFETCH_LAST      = 9'd336;
    localparam logic [8:0]  COPY_H_DOT         = 9'd257;
    localparam logic [8:0]  COPY_V_FIRST       = 9'd280;
    localparam logic [8:0]  COPY_V_LAST        = 9'd304;

    // Dots 1..256 fetch the visible tiles, 321..336 prefetch the first two of the next line.
    function automatic logic in_fetch_window(input logic [8:0] d);
        return ((d >= 9'd1) && (d <= FETCH_LAST_VISIBLE)) ||
               ((d >= PREFETCH_FIRST) && (d <= PREFETCH_LAST));
    endfunction

    function automatic logic [13:0] fetch_addr(input fetch_kind_e kind, input loopy_t v,
                                               input logic pattern_sel, input logic [7:0] tile);
        logic [13:0] addr;
        unique case (kind)
            FK_NT:    addr = NT_BASE | {2'b00, v[11:0]};
            FK_AT:    addr = AT_BASE | {2'b00, v[11:10], 4'b0000, v[9:7], v[4:2]};
            FK_PT_LO: addr = {1'b0, pattern_sel, tile, 1'b0, v[14:12]};
            FK_PT_HI: addr = {1'b0, pattern_sel, tile, 1'b1, v[14:12]};
            default:  addr = '0;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/loopy_scroll_reg.sv
// Loopy v/t scroll registers. The sequencer issues at most one command per clock;
// t_load is independent of those commands and of the pixel clock enable.
module loopy_scroll_reg
    import ppu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   t_load,
    input  loopy_t t_in,
    input  logic   inc_x,
    input  logic   inc_y,
    input  logic   copy_h,
    input  logic   copy_v,
    output loopy_t v
);

    loopy_t t;
    loopy_t v_next;

    function automatic loopy_t coarse_x_inc(input loopy_t cur);
        loopy_t r;
        r = cur;
        if (cur[4:0] == 5'd31) begin
            r[4:0] = 5'd0;
            r[10]  = ~cur[10];
        end else begin
            r[4:0] = cur[4:0] + 5'd1;
        end
        return r;
    endfunction

    function automatic loopy_t y_inc(input loopy_t cur);
        loopy_t r;
        r = cur;
        if (cur[14:12] != 3'd7) begin
            r[14:12] = cur[14:12] + 3'd1;
        end else begin
            r[14:12] = 3'd0;
            if (cur[9:5] == 5'd29) begin
                r[9:5] = 5'd0;
                r[11]  = ~cur[11];
            end else if (cur[9:5] == 5'd31) begin
                r[9:5] = 5'd0;
            end else begin
                r[9:5] = cur[9:5] + 5'd1;
            end
        end
        return r;
    endfunction

    // Next v; inc_y carries the dot-256 coarse-X step too (X and Y touch disjoint bits).
    always_comb begin
        v_next = v;
        if (inc_x) begin
            v_next = coarse_x_inc(v);
        end else if (inc_y) begin
            v_next = y_inc(coarse_x_inc(v));
        end else if (copy_h) begin
            v_next[10]  = t[10];
            v_next[4:0] = t[4:0];
        end else if (copy_v) begin
            v_next[14:11] = t[14:11];
            v_next[9:5]   = t[9:5];
        end
    end

    // v/t state; a copy on the same clock as t_load sees the old t.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            t <= '0;
        end else begin
            if (t_load) begin
                t <= t_in;
            end
            v <= v_next;
        end
    end

endmodule

// File: rtl/bg_fetch_sequencer.sv
// Background fetch scheduler: dot/scanline timing, 4-fetch tile sequence and loopy updates.
// Optional feature: define BG_ODD_FRAME_SKIP_EN to drop the last pre-render dot on odd
// frames while rendering is enabled.
module bg_fetch_sequencer
    import ppu_pkg::*;
#(
    parameter int unsigned LAST_DOT      = 340,
    parameter int unsigned LAST_SCANLINE = 261
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        rendering_en,
    input  logic        t_load,
    input  logic [14:0] t_in,
    input  logic        bg_pattern_sel,
    input  logic [7:0]  name_table,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    output logic [2:0]  fetch_cycle,
    output logic        shift_en,
    output logic [14:0] loopy,
    output logic [8:0]  dot,
    output logic [8:0]  scanline,
    output logic        frame_odd
);

    localparam logic [8:0] DOT_MAX  = 9'(LAST_DOT);
    localparam logic [8:0] LINE_MAX = 9'(LAST_SCANLINE);

    logic [8:0] dot_next;
    logic [8:0] scanline_next;
    logic       frame_odd_next;
    logic [2:0] fetch_cycle_next;
    logic       skip_dot;
    logic       fetch_line;
    logic       render_active;
    logic       fetching;
    logic       inc_x;
    logic       inc_y;
    logic       copy_h;
    logic       copy_v;

    function automatic logic line_is_fetch(input logic [8:0] s);
        return (s <= 9'd239) || (s == LINE_MAX);
    endfunction

`ifdef BG_ODD_FRAME_SKIP_EN
    assign skip_dot = frame_odd && rendering_en && (scanline == LINE_MAX) &&
                      (dot == DOT_MAX - 9'd1);
`else
    assign skip_dot = 1'b0;
`endif

    // Free-running dot/scanline/frame counters, advanced only on ce.
    always_comb begin
        dot_next       = dot;
        scanline_next  = scanline;
        frame_odd_next = frame_odd;
        if (ce) begin
            if ((dot == DOT_MAX) || skip_dot) begin
                dot_next = 9'd0;
                if (scanline == LINE_MAX) begin
                    scanline_next  = 9'd0;
                    frame_odd_next = ~frame_odd;
                end else begin
                    scanline_next = scanline + 9'd1;
                end
            end else begin
                dot_next = dot + 9'd1;
            end
        end
    end

    // Tile phase is registered alongside dot so it always equals (dot-1)[2:0] in the window.
    assign fetch_cycle_next = (line_is_fetch(scanline_next) && in_fetch_window(dot_next)) ?
                              (dot_next[2:0] - 3'd1) : 3'd0;

    // Timing state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot         <= '0;
            scanline    <= '0;
            frame_odd   <= 1'b0;
            fetch_cycle <= '0;
        end else if (ce) begin
            dot         <= dot_next;
            scanline    <= scanline_next;
            frame_odd   <= frame_odd_next;
            fetch_cycle <= fetch_cycle_next;
        end
    end

    // Fetch and shift outputs are combinational on rendering_en so dropping it aborts at once.
    assign fetch_line    = line_is_fetch(scanline);
    assign render_active = rendering_en && fetch_line;
    assign fetching      = render_active && in_fetch_window(dot);
    assign vram_rd       = fetching && !fetch_cycle[0];
    assign vram_addr     = vram_rd ? fetch_addr(fetch_kind_e'(fetch_cycle[2:1]), loopy,
                                                bg_pattern_sel, name_table) : 14'd0;
    // Shifting lags fetching by one dot: dots 2..257 and 322..337.
    assign shift_en      = render_active && in_fetch_window(dot - 9'd1);

    // One-hot loopy commands; dot 256 issues the combined X+Y increment.
    always_comb begin
        inc_x  = 1'b0;
        inc_y  = 1'b0;
        copy_h = 1'b0;
        copy_v = 1'b0;
        if (ce && render_active) begin
            if (dot == FETCH_LAST_VISIBLE) begin
                inc_y = 1'b1;
            end else if (fetching && (fetch_cycle == 3'd7)) begin
                inc_x = 1'b1;
            end else if (dot == COPY_H_DOT) begin
                copy_h = 1'b1;
            end else if ((scanline == LINE_MAX) && (dot >= COPY_V_FIRST) &&
                         (dot <= COPY_V_LAST)) begin
                copy_v = 1'b1;
            end
        end
    end

    loopy_scroll_reg u_loopy (
        .clk    (clk),
        .reset  (reset),
        .t_load (t_load),
        .t_in   (t_in),
        .inc_x  (inc_x),
        .inc_y  (inc_y),
        .copy_h (copy_h),
        .copy_v (copy_v),
        .v      (loopy)
    );

endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// Bench for bg_fetch_sequencer with a short frame (pre-render line = scanline 3).
// Fetch addresses go through a scoreboard queue; loopy/timing checks are directed.
module tb_bg_fetch_sequencer;

`ifdef BG_ODD_FRAME_SKIP_EN
    localparam int ODD_PRERENDER_LEN = 340;
`else
    localparam int ODD_PRERENDER_LEN = 341;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        rendering_en = 1'b0;
    logic        t_load = 1'b0;
    logic [14:0] t_in = '0;
    logic        bg_pattern_sel = 1'b1;
    logic [7:0]  name_table = 8'h24;
    logic [13:0] vram_addr;
    logic        vram_rd;
    logic [2:0]  fetch_cycle;
    logic        shift_en;
    logic [14:0] loopy;
    logic [8:0]  dot;
    logic [8:0]  scanline;
    logic        frame_odd;

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [13:0] exp_q[$];
    logic [13:0] exp_addr;

    bg_fetch_sequencer #(
        .LAST_DOT      (340),
        .LAST_SCANLINE (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ce             (ce),
        .rendering_en   (rendering_en),
        .t_load         (t_load),
        .t_in           (t_in),
        .bg_pattern_sel (bg_pattern_sel),
        .name_table     (name_table),
        .vram_addr      (vram_addr),
        .vram_rd        (vram_rd),
        .fetch_cycle    (fetch_cycle),
        .shift_en       (shift_en),
        .loopy          (loopy),
        .dot            (dot),
        .scanline       (scanline),
        .frame_odd      (frame_odd)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every fetch strobe while armed must match the next queued address.
    always @(negedge clk) begin
        if (mon_en && vram_rd) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_addr: got %h with no fetch expected", vram_addr);
            end else begin
                exp_addr = exp_q.pop_front();
                if (vram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL fetch_addr: got %h expected %h", vram_addr, exp_addr);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pos(input int line, input int d);
        int n;
        n = 0;
        while (!(scanline == 9'(line) && dot == 9'(d)) && n < 1500) begin
            step();
            n++;
        end
        if (n >= 1500) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout: line %0d dot %0d not reached", line, d);
        end
    endtask

    task automatic load_t(input logic [14:0] val);
        t_in   = val;
        t_load = 1'b1;
        step();
        t_load = 1'b0;
    endtask

    // Counts ce clocks from pre-render dot 0 until the frame wraps.
    task automatic measure_prerender(input string name, input int exp_len);
        int n;
        n = 0;
        goto_pos(3, 0);
        do begin
            step();
            n++;
        end while (!(scanline == 9'd0 && dot == 9'd0) && n < 400);
        check(name, n, exp_len);
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dot", int'(dot), 0);
        check("rst_scanline", int'(scanline), 0);
        check("rst_loopy", int'(loopy), 0);
        check("rst_frame_odd", int'(frame_odd), 0);
        check("rst_vram_rd", int'(vram_rd), 0);
        check("rst_vram_addr", int'(vram_addr), 0);
        check("rst_shift_en", int'(shift_en), 0);
        check("rst_fetch_cycle", int'(fetch_cycle), 0);

        // First tile of scanline 0 with v=0, pattern table 1, tile 0x24.
        exp_q.push_back(14'h2000);
        exp_q.push_back(14'h23C0);
        exp_q.push_back(14'h1240);
        exp_q.push_back(14'h1248);
        mon_en       = 1'b1;
        rendering_en = 1'b1;
        reset        = 1'b0;
        step();
        check("first_dot", int'(dot), 1);
        check("first_scanline", int'(scanline), 0);
        check("dot1_fetch_cycle", int'(fetch_cycle), 0);
        check("dot1_shift_en", int'(shift_en), 0);
        repeat (7) step();
        check("dot8_fetch_cycle", int'(fetch_cycle), 7);
        check("dot8_shift_en", int'(shift_en), 1);
        step();
        mon_en = 1'b0;
        check("tile0_loopy", int'(loopy), 'h0001);
        check("tile0_queue_empty", exp_q.size(), 0);

        // Clock enable low holds all state.
        ce = 1'b0;
        repeat (3) step();
        check("ce_hold_dot", int'(dot), 9);
        check("ce_hold_loopy", int'(loopy), 'h0001);
        ce = 1'b1;

        // Pre-render copies give v=0x001F; prefetch tile then coarse-X wrap at dot 328.
        goto_pos(2, 300);
        load_t(15'h001F);
        bg_pattern_sel = 1'b0;
        name_table     = 8'hA5;
        goto_pos(3, 305);
        check("copy_v_loopy", int'(loopy), 'h001F);
        exp_q.push_back(14'h201F);
        exp_q.push_back(14'h23C7);
        exp_q.push_back(14'h0A50);
        exp_q.push_back(14'h0A58);
        goto_pos(3, 320);
        mon_en = 1'b1;
        goto_pos(3, 329);
        mon_en = 1'b0;
        check("x_wrap_loopy", int'(loopy), 'h0400);
        check("prefetch_queue_empty", exp_q.size(), 0);
        goto_pos(0, 0);
        check("frame0_wrap_odd", int'(frame_odd), 1);

        // Frame 1: t=0x73A0 reaches v through pre-render copies; odd pre-render length.
        goto_pos(1, 100);
        load_t(15'h73A0);
        measure_prerender("odd_prerender_len", ODD_PRERENDER_LEN);
        check("frame1_wrap_odd", int'(frame_odd), 0);

        // Frame 2: fineY7/coarseY29 wraps to nametable toggle; t_load on the copy-H clock.
        goto_pos(0, 257);
        check("y_inc_29_loopy", int'(loopy), 'h0C02);
        load_t(15'h041F);
        check("copy_h_old_t_loopy", int'(loopy), 'h0800);
        goto_pos(1, 258);
        check("copy_h_new_t_loopy", int'(loopy), 'h1C1F);
        goto_pos(2, 100);
        load_t(15'h73E0);
        measure_prerender("even_prerender_len", 341);
        check("frame2_wrap_odd", int'(frame_odd), 1);

        // Frame 3: coarseY31 wraps without toggle; then abort mid-fetch.
        goto_pos(0, 257);
        check("y_inc_31_loopy", int'(loopy), 'h0402);
        step();
        check("y_inc_31_copy_h_loopy", int'(loopy), 'h0000);
        goto_pos(1, 5);
        check("pre_abort_vram_rd", int'(vram_rd), 1);
        check("pre_abort_vram_addr", int'(vram_addr), 'h0A50);
        rendering_en = 1'b0;
        #1;
        check("abort_vram_rd", int'(vram_rd), 0);
        check("abort_shift_en", int'(shift_en), 0);
        goto_pos(3, 0);
        check("frozen_loopy", int'(loopy), 'h0002);
        measure_prerender("odd_norender_len", 341);
        check("frozen_after_prerender", int'(loopy), 'h0002);

        // Asynchronous reset in the middle of an active fetch on an odd frame.
        goto_pos(3, 10);
        goto_pos(0, 0);
        check("frame5_odd", int'(frame_odd), 1);
        goto_pos(1, 149);
        rendering_en = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("mid_rst_dot", int'(dot), 0);
        check("mid_rst_scanline", int'(scanline), 0);
        check("mid_rst_loopy", int'(loopy), 0);
        check("mid_rst_frame_odd", int'(frame_odd), 0);
        check("mid_rst_vram_rd", int'(vram_rd), 0);
        check("mid_rst_vram_addr", int'(vram_addr), 0);
        check("mid_rst_shift_en", int'(shift_en), 0);
        check("mid_rst_fetch_cycle", int'(fetch_cycle), 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_dot", int'(dot), 1);
        check("post_rst_scanline", int'(scanline), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
